// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
// Multi-precision adder controller. One WORDS*SLICE_W-bit addition is done by
// time-sharing an external combinational SLICE_W-bit adder, one slice per
// cycle, LSB slice first. The carry between slices is held in carry_q.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a new operation, shared adder inputs parked at 0
// S_RUN  | driving slice k into the shared adder, capturing its result
// S_DONE | result valid, held stable until the consumer takes it
module wide_add_sequencer #(
  parameter int WORDS   = 4,
  parameter int SLICE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*SLICE_W-1:0]   op_a,
  input  logic [WORDS*SLICE_W-1:0]   op_b,
  input  logic                       op_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORDS*SLICE_W-1:0]   sum,
  output logic                       cout,
  output logic                       ovf,
  output logic [SLICE_W-1:0]         add_a,
  output logic [SLICE_W-1:0]         add_b,
  output logic                       add_cin,
  input  logic [SLICE_W-1:0]         add_sum,
  input  logic                       add_cout
);

  localparam int W  = WORDS * SLICE_W;
  // Keep the slice index at least one bit wide so WORDS=1 still elaborates.
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [KW-1:0]   k_q, k_d;
  logic            last_slice;
  int unsigned     base;

  assign last_slice = (k_q == KW'(WORDS - 1));

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

  // Next-state, slice sequencing and shared-adder drive.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    base    = int'(k_q) * SLICE_W;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          carry_d = 1'b0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[base +: SLICE_W];
        add_b   = b_q[base +: SLICE_W];
        add_cin = (k_q == '0) ? cin_q : carry_q;
        sum_d[base +: SLICE_W] = add_sum;
        carry_d = add_cout;
        if (last_slice) begin
          cout_d  = add_cout;
          // Signed overflow: operands agree in sign but the result does not.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[SLICE_W-1] != a_q[W-1]);
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer with an ideal 16-bit adder on the add_* ports.
module tb_wide_add_sequencer;

  localparam int WORDS   = 4;
  localparam int SLICE_W = 16;
  localparam int W       = WORDS * SLICE_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       op_a = '0;
  logic [W-1:0]       op_b = '0;
  logic               op_cin = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [W-1:0]       sum;
  logic               cout;
  logic               ovf;
  logic [SLICE_W-1:0] add_a;
  logic [SLICE_W-1:0] add_b;
  logic               add_cin;
  logic [SLICE_W-1:0] add_sum;
  logic               add_cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Ideal shared adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  wide_add_sequencer #(.WORDS(WORDS), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: result with empty scoreboard, sum=%h", name, sum);
    end else begin
      e = exp_q.pop_front();
      if (sum !== e.sum) begin
        errors++;
        $display("FAIL %s sum: got %h expected %h", name, sum, e.sum);
      end
      checks++;
      if (cout !== e.cout) begin
        errors++;
        $display("FAIL %s cout: got %b expected %b", name, cout, e.cout);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s ovf: got %b expected %b", name, ovf, e.ovf);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: sum=%h cout=%b ovf=%b expected zeros", sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset idle: add_a=%h add_b=%h add_cin=%b in_ready=%b", add_a, add_b, add_cin, in_ready);
    end
  endtask

  // One operation: accept, measure latency, optionally hold off the consumer.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input bit early_ready, input int hold);
    int n;
    logic [W-1:0] held;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
    end
    exp_q.push_back(model(a, b, c));
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    op_cin    = c;
    out_ready = early_ready;
    tick();
    in_valid = 1'b0;
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== WORDS) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, n, WORDS);
    end
    checks++;
    if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
      errors++;
      $display("FAIL %s adder idle in DONE: add_a=%h add_b=%h add_cin=%b", name, add_a, add_b, add_cin);
    end
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== held) begin
        errors++;
        $display("FAIL %s backpressure cycle %0d: out_valid=%b in_ready=%b sum=%h held=%h",
                 name, i, out_valid, in_ready, sum, held);
      end
    end
    in_valid = 1'b0;
    check_result(name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    run_op("carry_into_slice1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op("ripple_all",        64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 0);
    run_op("signed_ovf",        64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op("neg_ovf",           64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 64'h1234_1234_1234_1234, 64'h1234_1234_1234_1234, 1'b0, 1'b0, 5);
  endtask

  task automatic test_reset_midop();
    in_valid = 1'b1;
    op_a     = 64'hDEAD_BEEF_0000_1111;
    op_b     = 64'h1111_2222_3333_4444;
    op_cin   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: out_valid=%b in_ready=%b sum=%h cout=%b", out_valid, in_ready, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 64'h0000_0000_0000_A234, 64'h0000_0000_0000_5467, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int n_acc = 0;
    int n_res = 0;
    bit accept_now;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op_a      = 64'h0123_4567_89AB_CDEF;
    op_b      = 64'hFEDC_BA98_7654_3210;
    op_cin    = 1'b1;
    exp_q.push_back(model(op_a, op_b, op_cin));
    for (int c = 0; c < 40 && n_res < 2; c++) begin
      if (in_ready || out_valid) begin
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
          errors++;
          $display("FAIL b2b adder idle cycle %0d: add_a=%h add_b=%h add_cin=%b", c, add_a, add_b, add_cin);
        end
      end
      if (out_valid) begin
        check_result("b2b");
        n_res++;
      end
      accept_now = in_valid && in_ready;
      tick();
      if (accept_now) begin
        if (n_acc < 2) acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          op_a   = 64'h8000_0000_FFFF_FFFF;
          op_b   = 64'h8000_0000_0000_0001;
          op_cin = 1'b0;
          exp_q.push_back(model(op_a, op_b, op_cin));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 2 || n_res !== 2) begin
      errors++;
      $display("FAIL b2b counts: accepts=%0d results=%0d expected 2/2", n_acc, n_res);
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== WORDS + 2) begin
        errors++;
        $display("FAIL b2b interval: got %0d expected %0d", acc_cyc[1] - acc_cyc[0], WORDS + 2);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
